tbl_rd_ctrl_w8d16: RTL and testbench
====================================

# tbl_rd_ctrl_w8d16

Read-side controller for the 16-entry x 8-bit simple dual-port table RAMs in the hardware control point. It serves single-entry lookup requests and host-triggered full-table scans. It drives the RAM read port (rdaddress, rden, rd_aclr) and returns tagged read data. The RAM's read clock is tied to this block's clock; the write side belongs to the configuration writer and is outside this block.

## Interface
Parameters:
- RD_LATENCY, 2, cycles from the RAM sampling rden/rdaddress to q being valid (1 or 2 only).

Ports:
- i_clk  input  1  block clock; also drives the RAM rdclock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_lookup_req  input  1  lookup request; accepted when i_lookup_req & o_lookup_ready.
- i_lookup_addr  input  4  entry index for the lookup.
- o_lookup_ready  output  1  high in IDLE; combinational from state only.
- o_lookup_valid  output  1  one-cycle strobe; o_lookup_data is valid.
- o_lookup_data  output  8  entry contents for the lookup.
- i_scan_start  input  1  pulse that starts a full-table scan.
- o_scan_valid  output  1  one-cycle strobe per scanned entry.
- o_scan_addr  output  4  index of the entry on o_scan_data.
- o_scan_data  output  8  scanned entry contents.
- o_scan_done  output  1  pulse coincident with the o_scan_valid for entry 15.
- o_ram_rdaddress  output  4  RAM rdaddress.
- o_ram_rden  output  1  RAM rden.
- o_ram_rd_aclr  output  1  RAM rd_aclr; equals ~i_rst_n (combinational).
- i_ram_q  input  8  RAM q.

## Operation
- **FSM states: IDLE, SCAN.**
  - IDLE -> SCAN: i_scan_start sampled high.
  - SCAN -> IDLE: after the issue for address 15.
  - i_scan_start in SCAN is ignored (no queuing).
- **Lookup issue.** An accepted lookup at edge N registers o_ram_rden=1 and o_ram_rdaddress=i_lookup_addr during cycle N+1. Back-to-back lookups are accepted at one per cycle.
- **Scan issue.** In SCAN, a 4-bit counter starting at 0 drives one read per cycle with o_ram_rden=1, addresses 0..15 in order. The counter resets to 0 on SCAN exit.
- **Simultaneous lookup and scan start in IDLE.** The lookup is accepted and issued in cycle N+1. SCAN is entered at N+1 and address 0 is issued at N+2, so no issue slot collides.
- **Idle read port.** o_ram_rden=0 in any cycle with no issue. o_ram_rdaddress holds its last value.
- **Tag pipeline.** A shift register of depth RD_LATENCY carries {valid, is_scan, addr[3:0]} alongside each issue. On exit, i_ram_q is registered into o_lookup_data or o_scan_data, and the matching strobe fires. The other data register holds its value.
- **Ordering.** Results return in issue order. Lookups in flight when a scan starts complete normally.
- **Reset.** Assertion at any time clears all of the following:
  - FSM to IDLE, scan counter to 0, all tag valids to 0.
  - All registered outputs to 0: o_lookup_valid, o_lookup_data, o_scan_valid, o_scan_addr, o_scan_data, o_scan_done, o_ram_rden, o_ram_rdaddress.
  - o_ram_rd_aclr=1 during reset.
  - In-flight reads are discarded with no strobe. A partial scan is abandoned with no o_scan_done.

## Timing
- Lookup accepted at edge N: o_ram_rden high in cycle N+1; o_lookup_valid in cycle N+2+RD_LATENCY. That is 4 cycles with the default.
- Scan start sampled at edge N: address k issued in cycle N+1+k; o_scan_valid for k in cycle N+2+k+RD_LATENCY.
- A scan is 16 consecutive o_scan_valid cycles, with o_scan_done on the last one.
- o_lookup_ready is low from cycle N+1 through the cycle issuing address 15, and high again the following cycle.
- Throughput is one read per cycle, with no bubbles between lookups or between scan entries.

## Test plan
- **Single lookup.** Preload entry 5=0xA7, RD_LATENCY=2, lookup addr 5 -> o_lookup_valid 4 cycles after acceptance with data 0xA7; o_ram_rden high exactly one cycle.
- **Back-to-back lookups.** Lookups 3, 9, 3 on consecutive cycles (entries 3=0x11, 9=0x99) -> three consecutive valids carrying 0x11, 0x99, 0x11.
- **Full scan.** Preload entry k = 0x10+k, pulse scan -> 16 consecutive o_scan_valid with addr 0..15 and data 0x10..0x1F; o_scan_done only with addr 15; o_lookup_ready low for 16 cycles.
- **Simultaneous start.** i_lookup_req (addr 7, entry 0x77) and i_scan_start in the same IDLE cycle -> lookup result 0x77 precedes scan addr 0 by one cycle; no lost or duplicated entries; a second i_scan_start mid-scan produces no extra scan.
- **Reset mid-scan.** Assert i_rst_n=0 after scan entry 6 is issued -> all outputs 0 immediately, o_ram_rd_aclr=1, no o_scan_done. After release, a new lookup works normally.
- **RD_LATENCY=1 build.** Repeat the single-lookup and full-scan cases -> every result arrives one cycle earlier than with the default, data unchanged.

Source files
------------

// File: rtl/tbl_rd_ctrl_w8d16.sv
// Read-side controller for a 16 x 8 table RAM: single-entry lookups and full-table scans,
// with a tag pipeline that routes the RAM read data back to the lookup or scan result port.
module tbl_rd_ctrl_w8d16 #(
   parameter int RD_LATENCY = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_lookup_req,
   input  logic [3:0] i_lookup_addr,
   output logic       o_lookup_ready,
   output logic       o_lookup_valid,
   output logic [7:0] o_lookup_data,
   input  logic       i_scan_start,
   output logic       o_scan_valid,
   output logic [3:0] o_scan_addr,
   output logic [7:0] o_scan_data,
   output logic       o_scan_done,
   output logic [3:0] o_ram_rdaddress,
   output logic       o_ram_rden,
   output logic       o_ram_rd_aclr,
   input  logic [7:0] i_ram_q
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] scan_cnt;
   logic [3:0] scan_cnt_nxt;
   logic       scan_end;
   logic       scan_end_nxt;
   logic       issue_scan;
   logic       issue_scan_nxt;
   logic       issue_nxt;
   logic [3:0] issue_addr_nxt;
   logic       accept;

   // Handshake: a lookup transfers on any rising edge where i_lookup_req and o_lookup_ready are both high.
   assign o_lookup_ready = (state == IDLE);
   assign accept         = i_lookup_req & o_lookup_ready;
   assign o_ram_rd_aclr  = ~i_rst_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A lookup taking the same edge as a scan start pushes scan address 0 out by one cycle.
   always_comb begin
      state_nxt      = state;
      scan_cnt_nxt   = scan_cnt;
      scan_end_nxt   = 1'b0;
      issue_nxt      = 1'b0;
      issue_scan_nxt = 1'b0;
      issue_addr_nxt = o_ram_rdaddress;
      case (state)
         IDLE: begin
            if (accept) begin
               issue_nxt      = 1'b1;
               issue_addr_nxt = i_lookup_addr;
            end
            if (i_scan_start) begin
               state_nxt = SCAN;
               if (!accept) begin
                  issue_nxt      = 1'b1;
                  issue_scan_nxt = 1'b1;
                  issue_addr_nxt = 4'd0;
                  scan_cnt_nxt   = 4'd1;
               end
            end
         end
         SCAN: begin
            if (scan_end) begin
               state_nxt    = IDLE;
               scan_cnt_nxt = 4'd0;
            end else begin
               issue_nxt      = 1'b1;
               issue_scan_nxt = 1'b1;
               issue_addr_nxt = scan_cnt;
               scan_cnt_nxt   = scan_cnt + 4'd1;
               scan_end_nxt   = (scan_cnt == 4'd15);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // scan_end marks the cycle in which address 15 is on the read port.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scan_cnt        <= 4'd0;
         scan_end        <= 1'b0;
         issue_scan      <= 1'b0;
         o_ram_rden      <= 1'b0;
         o_ram_rdaddress <= 4'd0;
      end else begin
         scan_cnt        <= scan_cnt_nxt;
         scan_end        <= scan_end_nxt;
         issue_scan      <= issue_scan_nxt;
         o_ram_rden      <= issue_nxt;
         o_ram_rdaddress <= issue_addr_nxt;
      end
   end

   logic [RD_LATENCY-1:0] tag_valid;
   logic [RD_LATENCY-1:0] tag_scan;
   logic [3:0]            tag_addr [RD_LATENCY];
   logic                  head_valid;
   logic                  head_scan;
   logic [3:0]            head_addr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tag_valid <= '0;
         tag_scan  <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            tag_addr[i] <= 4'd0;
         end
      end else begin
         tag_valid[0] <= o_ram_rden;
         tag_scan[0]  <= issue_scan;
         tag_addr[0]  <= o_ram_rdaddress;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_scan[i]  <= tag_scan[i-1];
            tag_addr[i]  <= tag_addr[i-1];
         end
      end
   end

   // The oldest tag lines up with the cycle in which i_ram_q carries its data.
   assign head_valid = tag_valid[RD_LATENCY-1];
   assign head_scan  = tag_scan[RD_LATENCY-1];
   assign head_addr  = tag_addr[RD_LATENCY-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_lookup_valid <= 1'b0;
         o_lookup_data  <= 8'd0;
         o_scan_valid   <= 1'b0;
         o_scan_addr    <= 4'd0;
         o_scan_data    <= 8'd0;
         o_scan_done    <= 1'b0;
      end else begin
         o_lookup_valid <= head_valid & ~head_scan;
         o_scan_valid   <= head_valid & head_scan;
         o_scan_done    <= head_valid & head_scan & (head_addr == 4'd15);
         if (head_valid && !head_scan) begin
            o_lookup_data <= i_ram_q;
         end
         if (head_valid && head_scan) begin
            o_scan_data <= i_ram_q;
            o_scan_addr <= head_addr;
         end
      end
   end

endmodule

// File: tb/tb_tbl_rd_ctrl_w8d16.sv
// Bench for tbl_rd_ctrl_w8d16: one instance at RD_LATENCY=2 and one at RD_LATENCY=1,
// each with its own RAM read model over a shared table image, driven by the same inputs.
module tb_tbl_rd_ctrl_w8d16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       lookup_req;
   logic [3:0] lookup_addr;
   logic       scan_start;

   logic       a_ready, a_lvalid, a_svalid, a_sdone, a_rden, a_aclr;
   logic [7:0] a_ldata, a_sdata, a_q, a_p1;
   logic [3:0] a_saddr, a_raddr;
   logic       b_ready, b_lvalid, b_svalid, b_sdone, b_rden, b_aclr;
   logic [7:0] b_ldata, b_sdata, b_q;
   logic [3:0] b_saddr, b_raddr;

   logic [7:0] mem [16];
   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } look_vec_t;
   look_vec_t  vecs [5];
   logic [3:0] b2b_addr [3];
   logic [7:0] b2b_data [3];

   tbl_rd_ctrl_w8d16 #(.RD_LATENCY(2)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_lookup_req(lookup_req), .i_lookup_addr(lookup_addr),
      .o_lookup_ready(a_ready), .o_lookup_valid(a_lvalid), .o_lookup_data(a_ldata),
      .i_scan_start(scan_start), .o_scan_valid(a_svalid), .o_scan_addr(a_saddr),
      .o_scan_data(a_sdata), .o_scan_done(a_sdone),
      .o_ram_rdaddress(a_raddr), .o_ram_rden(a_rden), .o_ram_rd_aclr(a_aclr),
      .i_ram_q(a_q)
   );

   tbl_rd_ctrl_w8d16 #(.RD_LATENCY(1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_lookup_req(lookup_req), .i_lookup_addr(lookup_addr),
      .o_lookup_ready(b_ready), .o_lookup_valid(b_lvalid), .o_lookup_data(b_ldata),
      .i_scan_start(scan_start), .o_scan_valid(b_svalid), .o_scan_addr(b_saddr),
      .o_scan_data(b_sdata), .o_scan_done(b_sdone),
      .o_ram_rdaddress(b_raddr), .o_ram_rden(b_rden), .o_ram_rd_aclr(b_aclr),
      .i_ram_q(b_q)
   );

   // Two-stage RAM read (address register + output register) and single-stage RAM read.
   always_ff @(posedge clk or posedge a_aclr) begin
      if (a_aclr) begin
         a_p1 <= 8'd0;
         a_q  <= 8'd0;
      end else begin
         if (a_rden) a_p1 <= mem[a_raddr];
         a_q <= a_p1;
      end
   end

   always_ff @(posedge clk or posedge b_aclr) begin
      if (b_aclr) begin
         b_q <= 8'd0;
      end else if (b_rden) begin
         b_q <= mem[b_raddr];
      end
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // t counts negedges from the one where the stimulus starts; scan entry k is expected
   // at t = scan_t0 + k on the latency-2 instance and one cycle earlier on the other.
   task automatic check_res(input int t, input int scan_t0, input int look_t,
                            input logic [7:0] look_data);
      int   ka, kb;
      logic ea, eb;
      ka = t - scan_t0;
      kb = t - (scan_t0 - 1);
      ea = (ka >= 0) && (ka <= 15);
      eb = (kb >= 0) && (kb <= 15);
      chk1("a_scan_valid", a_svalid, ea);
      chk1("b_scan_valid", b_svalid, eb);
      chk1("a_scan_done", a_sdone, ea && (ka == 15));
      chk1("b_scan_done", b_sdone, eb && (kb == 15));
      if (ea) begin
         chk4("a_scan_addr", a_saddr, ka[3:0]);
         chk8("a_scan_data", a_sdata, mem[ka[3:0]]);
      end
      if (eb) begin
         chk4("b_scan_addr", b_saddr, kb[3:0]);
         chk8("b_scan_data", b_sdata, mem[kb[3:0]]);
      end
      chk1("a_lookup_valid", a_lvalid, t == look_t);
      chk1("b_lookup_valid", b_lvalid, t == look_t - 1);
      if (t == look_t)     chk8("a_lookup_data", a_ldata, look_data);
      if (t == look_t - 1) chk8("b_lookup_data", b_ldata, look_data);
   endtask

   task automatic check_reset_outputs();
      chk1("rst_a_ready", a_ready, 1'b1);
      chk1("rst_a_aclr", a_aclr, 1'b1);
      chk1("rst_a_rden", a_rden, 1'b0);
      chk4("rst_a_rdaddress", a_raddr, 4'd0);
      chk1("rst_a_lookup_valid", a_lvalid, 1'b0);
      chk8("rst_a_lookup_data", a_ldata, 8'd0);
      chk1("rst_a_scan_valid", a_svalid, 1'b0);
      chk4("rst_a_scan_addr", a_saddr, 4'd0);
      chk8("rst_a_scan_data", a_sdata, 8'd0);
      chk1("rst_a_scan_done", a_sdone, 1'b0);
      chk1("rst_b_aclr", b_aclr, 1'b1);
      chk1("rst_b_rden", b_rden, 1'b0);
      chk1("rst_b_scan_valid", b_svalid, 1'b0);
      chk4("rst_b_scan_addr", b_saddr, 4'd0);
      chk8("rst_b_scan_data", b_sdata, 8'd0);
      chk1("rst_b_scan_done", b_sdone, 1'b0);
   endtask

   // Called at a negedge with the controller idle; returns at a negedge.
   task automatic run_lookup(input logic [3:0] addr, input logic [7:0] data);
      for (int t = 0; t <= 6; t++) begin
         check_res(t, -100, 4, data);
         chk1("lk_a_rden", a_rden, t == 1);
         chk1("lk_b_rden", b_rden, t == 1);
         if (t == 1) begin
            chk4("lk_a_rdaddress", a_raddr, addr);
            chk4("lk_b_rdaddress", b_raddr, addr);
         end
         chk1("lk_a_ready", a_ready, 1'b1);
         lookup_req  = (t == 0);
         lookup_addr = addr;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      lookup_req  = 1'b0;
      lookup_addr = 4'd0;
      scan_start  = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      vecs[0] = '{addr: 4'd5,  data: 8'hA7};
      vecs[1] = '{addr: 4'd0,  data: 8'h3C};
      vecs[2] = '{addr: 4'd15, data: 8'hF0};
      vecs[3] = '{addr: 4'd10, data: 8'h55};
      vecs[4] = '{addr: 4'd5,  data: 8'hA7};
      b2b_addr[0] = 4'd3;  b2b_addr[1] = 4'd9;  b2b_addr[2] = 4'd3;
      b2b_data[0] = 8'h11; b2b_data[1] = 8'h99; b2b_data[2] = 8'h11;

      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);
      chk1("a_aclr_released", a_aclr, 1'b0);
      chk1("b_aclr_released", b_aclr, 1'b0);

      // Single lookups from the vector table.
      mem[5] = 8'hA7; mem[0] = 8'h3C; mem[15] = 8'hF0; mem[10] = 8'h55;
      for (int v = 0; v < 5; v++) begin
         run_lookup(vecs[v].addr, vecs[v].data);
      end

      // Back-to-back lookups 3, 9, 3.
      mem[3] = 8'h11; mem[9] = 8'h99;
      for (int t = 0; t <= 8; t++) begin
         chk1("b2b_a_valid", a_lvalid, (t >= 4) && (t <= 6));
         chk1("b2b_b_valid", b_lvalid, (t >= 3) && (t <= 5));
         if ((t >= 4) && (t <= 6)) chk8("b2b_a_data", a_ldata, b2b_data[t-4]);
         if ((t >= 3) && (t <= 5)) chk8("b2b_b_data", b_ldata, b2b_data[t-3]);
         chk1("b2b_a_rden", a_rden, (t >= 1) && (t <= 3));
         chk1("b2b_a_scan_valid", a_svalid, 1'b0);
         lookup_req  = (t <= 2);
         lookup_addr = (t <= 2) ? b2b_addr[t] : 4'd0;
         @(negedge clk);
      end

      // Full scan over entries 0x10..0x1F.
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      for (int t = 0; t <= 22; t++) begin
         check_res(t, 4, -100, 8'h00);
         chk1("scan_a_ready", a_ready, !((t >= 1) && (t <= 16)));
         chk1("scan_b_ready", b_ready, !((t >= 1) && (t <= 16)));
         chk1("scan_a_rden", a_rden, (t >= 1) && (t <= 16));
         if ((t >= 1) && (t <= 16)) chk4("scan_a_rdaddress", a_raddr, 4'(t - 1));
         scan_start = (t == 0);
         @(negedge clk);
      end

      // Lookup and scan start together, a second scan start mid-scan, a lookup refused in SCAN.
      mem[7] = 8'h77;
      for (int t = 0; t <= 25; t++) begin
         check_res(t, 5, 4, 8'h77);
         chk1("sim_a_ready", a_ready, !((t >= 1) && (t <= 17)));
         chk1("sim_a_rden", a_rden, (t >= 1) && (t <= 17));
         if (t == 1) chk4("sim_a_rdaddress_lookup", a_raddr, 4'd7);
         if ((t >= 2) && (t <= 17)) chk4("sim_a_rdaddress_scan", a_raddr, 4'(t - 2));
         lookup_req  = (t == 0) || (t == 8);
         lookup_addr = (t == 8) ? 4'd2 : 4'd7;
         scan_start  = (t == 0) || (t == 5);
         @(negedge clk);
      end

      // Reset in the cycle that issues scan entry 6.
      for (int t = 0; t <= 7; t++) begin
         check_res(t, 4, -100, 8'h00);
         if (t == 7) chk4("mid_a_rdaddress", a_raddr, 4'd6);
         scan_start = (t == 0);
         if (t < 7) @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) begin
         @(negedge clk);
         check_reset_outputs();
      end
      rst_n = 1'b1;
      for (int t = 0; t <= 8; t++) begin
         @(negedge clk);
         check_res(t, -100, -100, 8'h00);
         chk1("post_rst_a_rden", a_rden, 1'b0);
         chk1("post_rst_a_ready", a_ready, 1'b1);
      end
      mem[2] = 8'h2B;
      run_lookup(4'd2, 8'h2B);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
